ring_counter_multi: RTL
=======================

Name: ring_counter_multi

Overview:
- Parametrised N-bit shift-register counter; successor to the fixed one-hot ring counter.
- Modes: one-hot ring (N states) or Johnson/twisted-ring (2N states).
- Features: up/down direction, parallel load, explicit synchronous reset, deterministic self-correction of illegal states, binary position decode and wrap pulse.
- Used as a sequencer/phase generator in datapath control; replaces the X-detect reset workaround with a real reset port.

Parameters:
N, 4, counter width in flip-flops; legal range N >= 2.
PW, $clog2(2*N), width of pos output (derived; not overridden).

Ports:
clk  input  1  rising-edge clock.
reset  input  1  synchronous, active-high; highest priority.
en  input  1  advance one step on this clock edge.
mode  input  1  0 = one-hot ring, 1 = Johnson; sampled every cycle.
dir  input  1  0 = up (shift toward MSB), 1 = down (shift toward LSB).
load  input  1  parallel load of load_val; beats en.
load_val  input  N  value written on load; not validated on load.
q  output  N  registered counter state.
pos  output  PW  combinational binary index of q in the current mode's sequence.
illegal  output  1  combinational; q is not a legal state for current mode.
wrap  output  1  registered one-cycle pulse; last enabled step landed on START.

Behaviour:
- START state: ring = one-hot with bit 0 set (0..01); Johnson = all zeros.
- Legal states:
  - Ring: exactly one bit set.
  - Johnson: one contiguous run of ones anchored at bit 0 (0..01..1), or anchored at bit N-1 (1..10..0), or all zeros.
- Priority per edge: reset > load > en > hold.
- Reset: q <= START for the mode sampled that cycle; wrap <= 0. Reset asserted mid-sequence takes effect on the same edge.
- Load: q <= load_val verbatim, even if illegal; wrap <= 0.
- En step when q is legal:
  - Ring up: q <= {q[N-2:0], q[N-1]}.
  - Ring down: q <= {q[0], q[N-1:1]}.
  - Johnson up: q <= {q[N-2:0], ~q[N-1]}.
  - Johnson down: q <= {~q[0], q[N-1:1]}.
- En step when q is illegal: q <= START; self-correction takes exactly one enabled step.
- No en and no load: q holds and wrap <= 0. Illegal states persist while en = 0.
- wrap <= 1 only when an enabled, legal step produces START; corrective steps, load and reset drive 0.
- Johnson up sequence, N = 4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, back to 0000 (pos 0..7). Down traverses it in reverse.
- pos:
  - Ring: index of the set bit.
  - Johnson: index in the up sequence.
  - Illegal q: pos = 0.
- Mode change mid-run: q is unchanged on the switch. If q is illegal under the new mode, illegal asserts immediately and the next en corrects q to START. A legal one-hot in Johnson mode (e.g. 0001) continues normally.
- Direction may change on any cycle; the step uses dir sampled on that edge.
- No X-dependent logic; all flops are reset-initialised.

Test Plan:
- N=4, mode=0, dir=0: reset, then en for 5 cycles -> q = 0001, 0010, 0100, 1000, 0001. wrap high only on the cycle after q returns to 0001. pos = 0, 1, 2, 3, 0.
- N=4, mode=1: reset, dir=0, en 8 cycles -> full Johnson sequence ending at 0000 with one wrap pulse. Then dir=1, en 1 cycle -> q = 1000, pos = 7.
- mode=0: load 0110 -> illegal = 1, pos = 0. Hold en = 0 for 3 cycles -> q stays 0110. One en -> q = 0001, wrap = 0.
- mode=1: load 0101 -> illegal = 1. en -> q = 0000, wrap = 0. Next en -> 0001.
- Simultaneous events:
  - load = 1 and en = 1 with load_val = 0100 -> q = 0100, no shift.
  - reset = 1 together with load and en -> q = START.
- mode=0 at q = 0010, switch to mode=1 -> illegal = 1. en -> 0000. Parametrise N=6 and repeat the ring run: 6-step period, pos width 4.

Source files
------------

// File: rtl/ring_counter_multi.sv
// ring_counter_multi: N-bit shift-register counter used as a sequencer or
// phase generator. It runs either as a one-hot ring (N states) or as a
// Johnson / twisted ring (2N states), up or down, with parallel load, a
// synchronous reset, one-step recovery from illegal states, a binary position
// decode and a registered wrap pulse.
//
// Per-edge priority is reset > load > en > hold.
//   - An enabled step from an illegal state goes straight to START for the
//     current mode. That recovery step never raises wrap.
//   - A loaded value is taken verbatim, even if it is illegal.
//   - An illegal value stays in place until the next enabled step.
//   - mode and dir are sampled on every edge, so both may change mid-run.
module ring_counter_multi #(
    parameter int N  = 4,
    parameter int PW = $clog2(2 * N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          mode,
    input  logic          dir,
    input  logic          load,
    input  logic [N-1:0]  load_val,
    output logic [N-1:0]  q,
    output logic [PW-1:0] pos,
    output logic          illegal,
    output logic          wrap
);

    // Mode encoding: 0 = one-hot ring, 1 = Johnson.
    localparam logic MODE_RING    = 1'b0;
    localparam logic MODE_JOHNSON = 1'b1;

    // START state of each encoding.
    localparam logic [N-1:0] RING_START    = N'(1);
    localparam logic [N-1:0] JOHNSON_START = '0;

    // Step selector: {mode, dir}.
    typedef enum logic [1:0] {
        STEP_RING_UP      = 2'b00,
        STEP_RING_DOWN    = 2'b01,
        STEP_JOHNSON_UP   = 2'b10,
        STEP_JOHNSON_DOWN = 2'b11
    } step_e;

    logic [N-1:0]  state_q;
    logic [N-1:0]  state_d;
    logic          wrap_q;
    logic          wrap_d;

    logic [N-1:0]  start_state;
    logic [N-1:0]  step_state;
    step_e         step_sel;

    logic          ring_legal;
    logic [PW-1:0] ring_pos;
    logic          johnson_legal;
    logic [PW-1:0] johnson_pos;
    logic [N-1:0]  low_mask;

    logic          state_legal;

    // One-hot ring decode: legal means exactly one bit set, and pos is the
    // index of that bit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment. Otherwise a path that skips the
        // assignment would infer a latch.
        ring_pos   = '0;
        ring_legal = (state_q != '0) && ((state_q & (state_q - N'(1))) == '0);
        for (int i = 0; i < N; i++) begin
            if (state_q[i]) begin
                ring_pos = PW'(i);
            end
        end
        if (!ring_legal) begin
            ring_pos = '0;
        end
    end

    // Johnson decode: compare the state against every legal pattern.
    // A run of k ones anchored at bit 0 (k = 0..N) sits at index k.
    // A run of N-k ones anchored at bit N-1 (k = 1..N-1) is the complement of
    // the k-bit low mask, and sits at index N+k.
    always_comb begin
        johnson_legal = 1'b0;
        johnson_pos   = '0;
        low_mask      = '0;
        for (int k = 0; k <= N; k++) begin
            if (state_q == low_mask) begin
                johnson_legal = 1'b1;
                johnson_pos   = PW'(k);
            end
            if ((k >= 1) && (k <= N - 1) && (state_q == ~low_mask)) begin
                johnson_legal = 1'b1;
                johnson_pos   = PW'(N + k);
            end
            if (k < N) begin
                low_mask = {low_mask[N-2:0], 1'b1};
            end
        end
    end

    // Select the decode for the current mode. An illegal state reports pos 0.
    always_comb begin
        state_legal = (mode == MODE_JOHNSON) ? johnson_legal : ring_legal;
        pos         = '0;
        if (state_legal) begin
            pos = (mode == MODE_JOHNSON) ? johnson_pos : ring_pos;
        end
    end

    // Compute the START state and the one-step successor for the current
    // mode and direction.
    always_comb begin
        start_state = (mode == MODE_JOHNSON) ? JOHNSON_START : RING_START;
        step_sel    = step_e'({mode, dir});
        step_state  = state_q;
        unique case (step_sel)
            STEP_RING_UP:      step_state = {state_q[N-2:0], state_q[N-1]};
            STEP_RING_DOWN:    step_state = {state_q[0], state_q[N-1:1]};
            STEP_JOHNSON_UP:   step_state = {state_q[N-2:0], ~state_q[N-1]};
            STEP_JOHNSON_DOWN: step_state = {~state_q[0], state_q[N-1:1]};
            default:           step_state = state_q;
        endcase
    end

    // Next-state and wrap selection below reset: load > en > hold.
    // An illegal state recovers to START in one enabled step, without wrap.
    always_comb begin
        state_d = state_q;
        wrap_d  = 1'b0;
        if (load) begin
            state_d = load_val;
        end else if (en) begin
            if (!state_legal) begin
                state_d = start_state;
            end else begin
                state_d = step_state;
                wrap_d  = (step_state == start_state);
            end
        end
    end

    // State and wrap registers. The synchronous reset overrides everything
    // and loads the START state of the mode sampled on this edge.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. Every flop
        // then samples the values from before the edge, whatever order the
        // statements are written in.
        if (reset) begin
            state_q <= start_state;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q       = state_q;
    assign wrap    = wrap_q;
    assign illegal = ~state_legal;

    // The step decode always covers every {mode, dir} pair.
    // These mode names document the encoding used in the decodes above.
    logic unused_mode_names;
    assign unused_mode_names = MODE_RING ^ MODE_JOHNSON;

endmodule
